pat_gen: RTL
============

Name: pat_gen

Overview:
Serial pattern generator. It is the transmit side of the single-bit serial data stream that the team's pattern detectors consume. It latches a WIDTH-bit pattern on a start request and shifts it out MSB-first, one bit per clk. The pattern is optionally repeated with a programmable idle gap between repetitions. It drives detector test stimulus and link framing preambles.

Parameters:
WIDTH, 8, pattern length in bits (legal range 2..32)
CNT_W, 4, width of repeat and gap count fields

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only while busy=0
abort  input  1  synchronous stop; highest priority after rst
pattern  input  WIDTH  bits to send, MSB transmitted first
repeat_cnt  input  CNT_W  extra repetitions; total sends = repeat_cnt+1
gap_len  input  CNT_W  idle cycles between repetitions (0 = back-to-back)
data  output  1  serial bit out, registered
data_valid  output  1  high when data carries a pattern bit
busy  output  1  high from accepted start until the last bit or gap completes
done  output  1  one-cycle pulse after the final bit of the final repetition

Behaviour:
- Reset (rst=1, asynchronous): state IDLE; data=0, data_valid=0, busy=0, done=0; shift register, bit counter, rep counter and gap counter cleared. Effective immediately, including mid-transmission. No done is produced.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, SEND, GAP.
- IDLE: if start=1 at edge t:
  - latch pattern, repeat_cnt and gap_len into internal registers;
  - at the same edge load data=pattern[WIDTH-1], data_valid=1, busy=1, bit counter=0;
  - go to SEND.
  - Input changes after edge t do not affect the transfer.
- SEND: bit i (i = 0..WIDTH-1, i = 0 is MSB) is on data during the cycle following edge t+i (repetition 0).
  - On the edge where bit counter = WIDTH-1 and reps remaining > 0:
    - gap_len > 0: go to GAP; data=0, data_valid=0; gap counter loaded with gap_len.
    - gap_len = 0: reload shift register from the latched pattern; MSB on data next cycle; data_valid stays 1 (no bubble).
    - Decrement reps remaining in either case.
  - On the edge where bit counter = WIDTH-1 and reps remaining = 0: go to IDLE; data=0, data_valid=0, busy=0, done=1 for exactly one cycle.
- GAP: data=0, data_valid=0, busy=1 for exactly gap_len cycles. On the edge ending the last gap cycle, load MSB of the latched pattern and go to SEND.
- Total busy duration = (repeat_cnt+1)*WIDTH + repeat_cnt*gap_len cycles.
- start while busy=1: ignored, with no effect on latched values.
- start in the done cycle: busy=0 there, so it is accepted. The new transfer begins on the same edge done deasserts, giving back-to-back frames with no idle cycle.
- abort=1 at any edge while busy: next state IDLE; data=0, data_valid=0, busy=0, done stays 0. abort while idle has no effect. abort and start together while idle: abort wins and start is dropped.
- Counters never wrap. repeat_cnt and gap_len at all-ones (15) are legal maximums.
- data is 0 whenever data_valid=0.

Test Plan:
- Single send: pattern=8'hB3, repeat_cnt=0, gap_len=0, start pulse at edge t. Required: data = 1,0,1,1,0,0,1,1 in cycles t..t+7, data_valid=1 for those 8 cycles, busy=1 for 8 cycles, done=1 only in cycle t+8.
- Repeat with gap: pattern=8'hF0, repeat_cnt=2, gap_len=3. Required: 3 copies of 11110000, each separated by exactly 3 cycles of data_valid=0, data=0. busy=1 for 30 cycles; a single done pulse.
- Back-to-back repeats: pattern=8'h81, repeat_cnt=1, gap_len=0. Required: 16 contiguous valid bits 1000000110000001, no bubble, done once at cycle 16.
- Ignored start and latch isolation: start again and change pattern to 8'h00 mid-send. Required: the original 8'hB3 stream is unchanged and only one done pulse occurs. Then start in the done cycle. Required: the next frame's MSB appears in the following cycle.
- Abort and async reset: abort at bit 4 of an 8'hFF send. Required: data_valid=0 and busy=0 next cycle, with no done. Assert rst asynchronously mid-GAP (no clock edge). Required: all outputs 0 immediately. A fresh start after rst release behaves as in scenario 1.
- Loopback: drive data into a serial pattern detector clocked on the same clk, with a pattern containing the detector's target sequence. Required: the detector flag asserts at the cycle predicted from bit position.

Source files
------------

// File: rtl/pat_gen.sv
// Serial pattern generator.
// Latches a WIDTH-bit pattern on an accepted start and shifts it out MSB-first,
// one bit per clock. The pattern can be repeated repeat_cnt extra times, with
// gap_len idle cycles between copies. All outputs come straight from flops.
module pat_gen #(
  parameter int WIDTH = 8,   // pattern length, 2..32
  parameter int CNT_W = 4    // width of the repeat and gap count fields
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [CNT_W-1:0] gap_len,
  output logic             data,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

  localparam int             BCW      = $clog2(WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Current-state registers.
  state_t           state_q;
  logic [WIDTH-1:0] pat_q;      // pattern latched at the accepted start
  logic [WIDTH-1:0] shreg_q;    // bits still to be sent in this copy, MSB next
  logic [BCW-1:0]   bit_q;      // index of the bit currently on data
  logic [CNT_W-1:0] reps_q;     // copies still to send after the current one
  logic [CNT_W-1:0] gap_len_q;  // latched idle length between copies
  logic [CNT_W-1:0] gap_q;      // idle cycles left in the current gap
  logic             data_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  // Next-state values.
  state_t           state_d;
  logic [WIDTH-1:0] pat_d;
  logic [WIDTH-1:0] shreg_d;
  logic [BCW-1:0]   bit_d;
  logic [CNT_W-1:0] reps_d;
  logic [CNT_W-1:0] gap_len_d;
  logic [CNT_W-1:0] gap_d;
  logic             data_d;
  logic             valid_d;
  logic             busy_d;
  logic             done_d;

  // Next-state and next-output decode for the IDLE / SEND / GAP sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    pat_d     = pat_q;
    shreg_d   = shreg_q;
    bit_d     = bit_q;
    reps_d    = reps_q;
    gap_len_d = gap_len_q;
    gap_d     = gap_q;
    data_d    = 1'b0;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        // abort on the same edge as start drops the request.
        if (start && !abort) begin
          pat_d     = pattern;
          reps_d    = repeat_cnt;
          gap_len_d = gap_len;
          data_d    = pattern[WIDTH-1];
          valid_d   = 1'b1;
          shreg_d   = {pattern[WIDTH-2:0], 1'b0};
          bit_d     = '0;
          busy_d    = 1'b1;
          state_d   = SEND;
        end
      end

      SEND: begin
        busy_d = 1'b1;
        if (bit_q != LAST_BIT) begin
          data_d  = shreg_q[WIDTH-1];
          valid_d = 1'b1;
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          bit_d   = bit_q + BIT_ONE;
        end else if (reps_q != '0) begin
          reps_d = reps_q - CNT_ONE;
          if (gap_len_q != '0) begin
            // Enter the idle gap; data/data_valid keep their zero defaults.
            gap_d   = gap_len_q;
            state_d = GAP;
          end else begin
            // Back-to-back copy: next MSB follows the last bit with no bubble.
            data_d  = pat_q[WIDTH-1];
            valid_d = 1'b1;
            shreg_d = {pat_q[WIDTH-2:0], 1'b0};
            bit_d   = '0;
          end
        end else begin
          // Final bit of the final copy has been shown: finish up.
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bit_d   = '0;
          state_d = IDLE;
        end
      end

      GAP: begin
        busy_d = 1'b1;
        if (gap_q == CNT_ONE) begin
          data_d  = pat_q[WIDTH-1];
          valid_d = 1'b1;
          shreg_d = {pat_q[WIDTH-2:0], 1'b0};
          bit_d   = '0;
          gap_d   = '0;
          state_d = SEND;
        end else begin
          gap_d = gap_q - CNT_ONE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // abort overrides everything above while a transfer is in progress.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      data_d  = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      bit_d   = '0;
      reps_d  = '0;
      gap_d   = '0;
    end
  end

  // State and output registers with asynchronous active-high clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      shreg_q   <= '0;
      bit_q     <= '0;
      reps_q    <= '0;
      gap_len_q <= '0;
      gap_q     <= '0;
      data_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      pat_q     <= pat_d;
      shreg_q   <= shreg_d;
      bit_q     <= bit_d;
      reps_q    <= reps_d;
      gap_len_q <= gap_len_d;
      gap_q     <= gap_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
